// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl
//   Clocked priority interrupt controller. Request lines are captured into
//   pending bits (rising-edge or level mode), masked per channel by en, and
//   arbitrated by level (0 highest) and then by channel (0 highest). The
//   winner is presented on a valid/ack handshake. In edge mode its pending
//   bit is retired on ack.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   NLVL*NCH request lines, bit l*NCH+c = level l, channel c
//   en         in   NCH channel enables, shared by all levels
//   irq_valid  out  a granted interrupt is presented
//   irq_level  out  level of the presented interrupt
//   irq_id     out  channel of the presented interrupt
//   irq_ack    in   consumer accepts the presented interrupt
//   lvl_pend   out  registered per-level "some enabled channel pending"
//   pend       out  registered raw pending vector (not masked by en)
module irq_prio_ctrl #(
  parameter int NCH  = 9,
  parameter int NLVL = 3,
  parameter int EDGE = 1,
  parameter int IDW  = (NCH  > 1) ? $clog2(NCH)  : 1,
  parameter int LVW  = (NLVL > 1) ? $clog2(NLVL) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NLVL*NCH-1:0]  req,
  input  logic [NCH-1:0]       en,
  output logic                 irq_valid,
  output logic [LVW-1:0]       irq_level,
  output logic [IDW-1:0]       irq_id,
  input  logic                 irq_ack,
  output logic [NLVL-1:0]      lvl_pend,
  output logic [NLVL*NCH-1:0]  pend
);

  localparam int NB = NLVL * NCH;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [NB-1:0]  elig;
  logic [NB-1:0]  pend_n;
  logic [NLVL-1:0] lvl_n;
  logic           win_found;
  logic [LVW-1:0] win_lvl;
  logic [IDW-1:0] win_id;
  logic [LVW-1:0] level_n;
  logic [IDW-1:0] id_n;

  // A disabled channel keeps its pending bit; it is only hidden from
  // arbitration and from lvl_pend.
  always_comb begin
    elig = pend & {NLVL{en}};
  end

  generate
    if (EDGE != 0) begin : g_edge
      logic [NB-1:0] req_q;
      logic [NB-1:0] retire;

      // req_q resets to 0, so a request held high through reset release
      // is seen as a rising edge in the first cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          req_q <= '0;
        end else begin
          req_q <= req;
        end
      end

      // One-hot retire of the granted bit when it is acknowledged.
      always_comb begin
        retire = '0;
        for (int l = 0; l < NLVL; l++) begin
          for (int c = 0; c < NCH; c++) begin
            retire[l*NCH+c] = (state == GRANT) && irq_ack &&
                              (irq_level == LVW'(l)) && (irq_id == IDW'(c));
          end
        end
      end

      // A new edge wins over a retire of the same bit.
      assign pend_n = (pend & ~retire) | (req & ~req_q);
    end else begin : g_level
      assign pend_n = req;
    end
  endgenerate

  // Fixed-priority arbiter: scanning from the lowest priority upwards and
  // overwriting leaves the lowest (level, channel) pair as the winner.
  always_comb begin
    win_found = 1'b0;
    win_lvl   = '0;
    win_id    = '0;
    for (int l = NLVL - 1; l >= 0; l--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (elig[l*NCH+c]) begin
          win_found = 1'b1;
          win_lvl   = LVW'(l);
          win_id    = IDW'(c);
        end
      end
    end
  end

  always_comb begin
    lvl_n = '0;
    for (int l = 0; l < NLVL; l++) begin
      lvl_n[l] = |elig[l*NCH +: NCH];
    end
  end

  // Grant FSM: the presented interrupt is frozen in GRANT (no preemption)
  // until acknowledged; level/id keep their last value while idle.
  always_comb begin
    state_n = state;
    level_n = irq_level;
    id_n    = irq_id;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          level_n = win_lvl;
          id_n    = win_id;
        end
      end
      GRANT: begin
        if (irq_ack) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_level <= '0;
      irq_id    <= '0;
      pend      <= '0;
      lvl_pend  <= '0;
    end else begin
      state     <= state_n;
      irq_level <= level_n;
      irq_id    <= id_n;
      pend      <= pend_n;
      lvl_pend  <= lvl_n;
    end
  end

  assign irq_valid = (state == GRANT);

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb_irq_prio_ctrl
//   Drives an edge-mode instance (A) and a level-mode instance (B) of
//   irq_prio_ctrl with directed and random stimulus, comparing every cycle
//   against a behavioural model of the pending/grant rules.
module tb_irq_prio_ctrl;

  localparam int NCH  = 9;
  localparam int NLVL = 3;
  localparam int NB   = NCH * NLVL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [NB-1:0]   reqA, reqB;
  logic [NCH-1:0]  enA, enB;
  logic            ackA, ackB;

  logic            validA, validB;
  logic [1:0]      levelA, levelB;
  logic [3:0]      idA, idB;
  logic [NLVL-1:0] lvlA, lvlB;
  logic [NB-1:0]   pendA, pendB;

  int testCount = 0;
  int failCount = 0;

  // Model state, index 0 = edge-mode DUT A, index 1 = level-mode DUT B
  logic [NB-1:0]   mPend [2];
  logic [NB-1:0]   mReqQ [2];
  logic [NLVL-1:0] mLvl  [2];
  logic            mValid[2];
  logic [1:0]      mLevel[2];
  logic [3:0]      mId   [2];

  always #5 clk = ~clk;

  irq_prio_ctrl #(.NCH(NCH), .NLVL(NLVL), .EDGE(1)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .en(enA),
    .irq_valid(validA), .irq_level(levelA), .irq_id(idA), .irq_ack(ackA),
    .lvl_pend(lvlA), .pend(pendA)
  );

  irq_prio_ctrl #(.NCH(NCH), .NLVL(NLVL), .EDGE(0)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .en(enB),
    .irq_valid(validB), .irq_level(levelB), .irq_id(idB), .irq_ack(ackB),
    .lvl_pend(lvlB), .pend(pendB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mPend[d]  = '0;
      mReqQ[d]  = '0;
      mLvl[d]   = '0;
      mValid[d] = 1'b0;
      mLevel[d] = '0;
      mId[d]    = '0;
    end
  endtask

  // One clock of the spec rules: pending capture, retire on ack, and a
  // grant of the lowest flat index (flat order == (level, channel) order).
  task automatic modelStep(input int d, input logic [NB-1:0] r,
                           input logic [NCH-1:0] e, input logic a, input bit edgeMode);
    logic [NB-1:0] elig, ret, np;
    int first;
    elig = mPend[d] & {NLVL{e}};
    ret  = '0;
    if (mValid[d] && a) ret[int'(mLevel[d]) * NCH + int'(mId[d])] = 1'b1;
    np = edgeMode ? ((mPend[d] & ~ret) | (r & ~mReqQ[d])) : r;
    for (int l = 0; l < NLVL; l++) mLvl[d][l] = |elig[l*NCH +: NCH];
    if (mValid[d]) begin
      if (a) mValid[d] = 1'b0;
    end else if (elig != '0) begin
      first = 0;
      for (int k = NB - 1; k >= 0; k--) if (elig[k]) first = k;
      mValid[d] = 1'b1;
      mLevel[d] = 2'(first / NCH);
      mId[d]    = 4'(first % NCH);
    end
    mPend[d] = np;
    mReqQ[d] = r;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".A.valid"}, 32'(validA), 32'(mValid[0]));
    chk({tag, ".A.level"}, 32'(levelA), 32'(mLevel[0]));
    chk({tag, ".A.id"},    32'(idA),    32'(mId[0]));
    chk({tag, ".A.lvl"},   32'(lvlA),   32'(mLvl[0]));
    chk({tag, ".A.pend"},  32'(pendA),  32'(mPend[0]));
    chk({tag, ".B.valid"}, 32'(validB), 32'(mValid[1]));
    chk({tag, ".B.level"}, 32'(levelB), 32'(mLevel[1]));
    chk({tag, ".B.id"},    32'(idB),    32'(mId[1]));
    chk({tag, ".B.lvl"},   32'(lvlB),   32'(mLvl[1]));
    chk({tag, ".B.pend"},  32'(pendB),  32'(mPend[1]));
  endtask

  // Advance one clock with the inputs currently applied, then compare.
  task automatic applyStimulus(input string tag);
    @(posedge clk);
    #1;
    modelStep(0, reqA, enA, ackA, 1'b1);
    modelStep(1, reqB, enB, ackB, 1'b0);
    checkOutput(tag);
  endtask

  initial begin
    reqA = '1; enA = '1; ackA = 1'b0;
    reqB = '0; enB = '1; ackB = 1'b0;
    rst  = 1'b1;
    modelReset();
    #2;
    checkOutput("reset");
    chk("reset.validA", 32'(validA), 32'd0);
    #14;
    rst = 1'b0;

    // req held high through reset release counts as an edge
    applyStimulus("rel1");
    chk("rel1.pendA", 32'(pendA), 32'h7FF_FFFF);
    applyStimulus("rel2");

    for (int k = 0; k < NB; k++) begin
      chk("order.valid", 32'(validA), 32'd1);
      chk("order.level", 32'(levelA), 32'(k / NCH));
      chk("order.id",    32'(idA),    32'(k % NCH));
      ackA = 1'b1;
      applyStimulus("order.ack");
      ackA = 1'b0;
      if (k < NB - 1) applyStimulus("order.gap");
    end
    applyStimulus("order.done");
    chk("order.lvlA", 32'(lvlA), 32'd0);
    chk("order.idle", 32'(validA), 32'd0);
    reqA = '0;
    applyStimulus("clr");

    // no preemption of a grant by a higher-priority request
    reqA[13] = 1'b1;
    applyStimulus("pre.req");
    reqA = '0;
    applyStimulus("pre.grant");
    chk("pre.lvl14", 32'(levelA), 32'd1);
    chk("pre.id14",  32'(idA),    32'd4);
    reqA[2] = 1'b1;
    applyStimulus("pre.hi");
    reqA = '0;
    chk("pre.hold", 32'({validA, levelA, idA}), 32'({1'b1, 2'd1, 4'd4}));
    applyStimulus("pre.wait");
    chk("pre.lvl0", 32'(lvlA[0]), 32'd1);
    ackA = 1'b1;
    applyStimulus("pre.ack");
    ackA = 1'b0;
    applyStimulus("pre.next");
    chk("pre.next", 32'({validA, levelA, idA}), 32'({1'b1, 2'd0, 4'd2}));
    ackA = 1'b1;
    applyStimulus("pre.ack2");
    ackA = 1'b0;
    applyStimulus("pre.end");

    // masked channel keeps its pending bit
    enA[5] = 1'b0;
    reqA[23] = 1'b1;
    applyStimulus("mask.req");
    reqA = '0;
    applyStimulus("mask.w1");
    applyStimulus("mask.w2");
    chk("mask.valid", 32'(validA), 32'd0);
    chk("mask.lvl",   32'(lvlA),   32'd0);
    chk("mask.pend",  32'(pendA[23]), 32'd1);
    enA[5] = 1'b1;
    applyStimulus("mask.en");
    chk("mask.lvlon", 32'(lvlA), 32'b100);
    chk("mask.grant", 32'({validA, levelA, idA}), 32'({1'b1, 2'd2, 4'd5}));
    ackA = 1'b1;
    applyStimulus("mask.ack");
    ackA = 1'b0;
    applyStimulus("mask.end");

    // set wins over retire of the same bit
    reqA[3] = 1'b1;
    applyStimulus("rt.req");
    reqA = '0;
    applyStimulus("rt.grant");
    chk("rt.grant", 32'({validA, levelA, idA}), 32'({1'b1, 2'd0, 4'd3}));
    reqA[3] = 1'b1;
    ackA = 1'b1;
    applyStimulus("rt.both");
    chk("rt.pend",  32'(pendA[3]), 32'd1);
    chk("rt.gap",   32'(validA),   32'd0);
    reqA = '0;
    ackA = 1'b0;
    applyStimulus("rt.regrant");
    chk("rt.regrant", 32'({validA, levelA, idA}), 32'({1'b1, 2'd0, 4'd3}));
    ackA = 1'b1;
    applyStimulus("rt.ack");
    ackA = 1'b0;
    applyStimulus("rt.end");

    // level mode: held request re-granted every 2 cycles
    reqB[9] = 1'b1;
    applyStimulus("lv.req");
    applyStimulus("lv.grant");
    chk("lv.grant", 32'({validB, levelB, idB}), 32'({1'b1, 2'd1, 4'd0}));
    for (int i = 0; i < 3; i++) begin
      ackB = 1'b1;
      applyStimulus("lv.ack");
      chk("lv.gap", 32'(validB), 32'd0);
      ackB = 1'b0;
      applyStimulus("lv.re");
      chk("lv.re", 32'({validB, levelB, idB}), 32'({1'b1, 2'd1, 4'd0}));
    end
    ackB = 1'b1;
    reqB = '0;
    applyStimulus("lv.drop");
    ackB = 1'b0;
    applyStimulus("lv.s1");
    applyStimulus("lv.s2");
    chk("lv.stop", 32'(validB), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reqA = NB'($urandom) & NB'($urandom) & NB'($urandom);
      reqB = NB'($urandom) & NB'($urandom);
      enA  = NCH'($urandom) | NCH'($urandom);
      enB  = NCH'($urandom) | NCH'($urandom);
      ackA = ($urandom_range(0, 2) != 0);
      ackB = ($urandom_range(0, 2) != 0);
      applyStimulus("rand");
    end

    // asynchronous reset in the middle of a grant
    reqA = '0; reqB = '0; ackA = 1'b0; ackB = 1'b0; enA = '1; enB = '1;
    applyStimulus("ar.clr");
    reqA = 27'h0000413;
    reqB = 27'h0000201;
    applyStimulus("ar.req");
    applyStimulus("ar.grant");
    chk("ar.validA", 32'(validA), 32'd1);
    #3;
    rst  = 1'b1;
    reqA = '0;
    reqB = '0;
    modelReset();
    #1;
    chk("ar.drop",  32'(validA), 32'd0);
    chk("ar.pendA", 32'(pendA),  32'd0);
    chk("ar.lvlA",  32'(lvlA),   32'd0);
    checkOutput("ar.rst");
    #7;
    rst = 1'b0;
    applyStimulus("ar.p1");
    applyStimulus("ar.p2");
    applyStimulus("ar.p3");
    chk("ar.nogrant", 32'(validA), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, clocked successor to the combinational 27-input priority interrupt encoder in the AQFP benchmark set. It generalises the fixed three-bus, nine-channel structure to NLVL priority levels of NCH channels each, with a per-channel enable mask. It latches requests into pending bits and arbitrates by level and then by channel. The winner is presented through a valid/ack handshake, and its pending bit is retired on acknowledge. It sits between peripheral request lines and the core's interrupt entry logic.

## Interface
- NCH, 9: channels per level, 1..32
- NLVL, 3: priority levels, 1..8; level 0 is highest
- EDGE, 1: 1 = rising-edge capture into pending; 0 = level mode, where pending follows req
- IDW, max(1,clog2(NCH)): width of irq_id
- LVW, max(1,clog2(NLVL)): width of irq_level
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NLVL*NCH  request lines; bit l*NCH+c is level l, channel c
- en  in  NCH  channel enable mask, shared by all levels (bit c gates channel c on every level)
- irq_valid  out  1  a granted interrupt is presented
- irq_level  out  LVW  level of the presented interrupt
- irq_id  out  IDW  channel of the presented interrupt
- irq_ack  in  1  consumer accepts the presented interrupt
- lvl_pend  out  NLVL  registered per-level flag: some enabled channel is pending at that level
- pend  out  NLVL*NCH  registered raw pending vector, not masked by en

## Operation
- Reset, asynchronous: req_q=0, pend=0, lvl_pend=0, irq_valid=0, irq_level=0, irq_id=0, FSM=IDLE.
- Capture, EDGE=1:
  - set(l,c) = req & ~req_q.
  - pend(l,c) is set by set(l,c) and cleared by a retire of (l,c).
  - Set and retire of the same bit in the same cycle: set wins, and the bit stays 1.
  - req high through reset deassertion counts as a rising edge in the first cycle after reset.
- Capture, EDGE=0:
  - pend(l,c) <= req(l,c) every cycle.
  - Retire has no effect on pend; the source must drop req itself.
- Eligibility: elig(l,c) = pend(l,c) & en(c).
  - A disabled channel keeps its pending bit.
  - The bit becomes eligible as soon as en returns high.
- Arbitration, combinational on the elig vector: lowest level index first, then lowest channel index within that level.
- FSM:
  - IDLE: if any elig, load irq_level/irq_id from the arbiter, set irq_valid=1, go to GRANT. Otherwise stay in IDLE with irq_valid=0.
  - GRANT: irq_valid, irq_level and irq_id are held stable. There is no preemption; a newly eligible higher-priority request waits.
    - Stable even if en of the granted channel drops or its req drops.
    - On irq_ack=1: retire pend(irq_level,irq_id), clear irq_valid, go to IDLE.
- irq_ack in IDLE is ignored.
- irq_level and irq_id keep their last value while irq_valid=0.
- lvl_pend(l) <= OR over c of elig(l,c), registered every cycle, independent of FSM state.

## Timing
- Request to grant, EDGE=1: req rises before edge k, pend=1 after edge k, irq_valid=1 after edge k+1. Latency is 2 cycles from the idle state.
- EDGE=0 has the same latency.
- lvl_pend reflects pend one cycle late: pend after edge k gives lvl_pend after edge k+1.
- Ack: irq_ack sampled high at edge j gives irq_valid=0 and pend cleared after edge j.
- The next grant follows at the earliest after edge j+1, so there is exactly one idle cycle between back-to-back grants.
- irq_ack held high continuously retires at most one interrupt every 2 cycles.
- Asynchronous reset mid-GRANT drops irq_valid immediately. All pending bits are lost.

## Test plan
- Reset with req all 1s and en all 1s, EDGE=1, NCH=9, NLVL=3: outputs 0 during reset. Release reset: pend=all 1s after the 1st edge and irq_valid=1 with level 0, id 0 after the 2nd. Acking each grant yields 27 grants in ascending (level, id) order, then lvl_pend=000.
- In GRANT on (1,4), pulse req(0,2): irq_valid stays on (1,4) until ack. The next grant is (0,2) after a one-cycle gap, with lvl_pend(0)=1 meanwhile.
- en(5)=0 with req(2,5) pulsed: no grant and lvl_pend=000, while pend bit 23 = 1. Set en(5)=1: lvl_pend=100 one edge later; grant (2,5) follows.
- Granted (0,3): pulse req(0,3) again in the same cycle as ack. pend(0,3) stays 1 and (0,3) is re-granted after the one-cycle gap.
- EDGE=0: hold req(1,0) high and ack the grant. It is re-granted every 2 cycles until req drops. After req drops, grants stop within 2 cycles.
- Assert rst in the middle of a GRANT (not aligned to clk) with several bits pending: irq_valid, pend and lvl_pend go to 0 immediately. No grant occurs after release unless req toggles again.
